// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller.
//   - lsb_type_e   : load/store type encodings used by the LSB interface
//   - state_e      : controller FSM states
//   - MEM_IO_BASE  : first I/O-mapped byte address
//   - access_size  : number of bytes moved for a given type
//   - extend_load  : sign/zero extension of an assembled load word
package mem_ctrl_pkg;

    localparam logic [31:0] MEM_IO_BASE = 32'h0003_0000;

    typedef enum logic [3:0] {
        LSB_LB  = 4'b0000,
        LSB_LH  = 4'b0001,
        LSB_LW  = 4'b0010,
        LSB_LBU = 4'b0100,
        LSB_LHU = 4'b0101,
        LSB_SB  = 4'b1000,
        LSB_SH  = 4'b1001,
        LSB_SW  = 4'b1010
    } lsb_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_FETCH
    } state_e;

    // Size is encoded in the low two bits for every load and store type.
    function automatic logic [2:0] access_size(input logic [1:0] size_bits);
        case (size_bits)
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    // type_low = lsb_type[2:0]; bit 2 set means unsigned.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  type_low);
        case (type_low[1:0])
            2'b00:   extend_load = type_low[2] ? {24'h0, word[7:0]}
                                               : {{24{word[7]}}, word[7:0]};
            2'b01:   extend_load = type_low[2] ? {16'h0, word[15:0]}
                                               : {{16{word[15]}}, word[15:0]};
            default: extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes LSB loads/stores and instruction fetches onto a
// byte-wide RAM bus, one byte per cycle, little-endian.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable), clear (flush)
//   mem_din / mem_dout / mem_a / mem_wr : byte RAM bus (read data lags address
//                                         by one cycle)
//   io_buffer_full                      : I/O sink back-pressure
//   if_enable / if_addr -> if_finished / if_data           : word fetch port
//   ls_enable / addr / store_val / lsb_type -> ls_finished / load_val : LSB port
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = MEM_IO_BASE
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_finished,
    output logic [31:0] if_data,
    input  logic        ls_enable,
    input  logic [31:0] addr,
    input  logic [31:0] store_val,
    input  logic [3:0]  lsb_type,
    output logic        ls_finished,
    output logic [31:0] load_val
);

    state_e      state_reg;
    logic [2:0]  k_reg;          // byte index within the access
    logic [2:0]  n_reg;          // access size in bytes
    logic [31:0] base_reg;
    logic [2:0]  type_reg;       // signedness + size of the pending load
    logic [23:0] sv_reg;         // store bytes not yet placed on mem_dout
    logic [23:0] assm_reg;       // load bytes gathered so far (top-aligned)
    logic        suppress_reg;   // store was flushed: finish without a pulse
    logic [31:0] mem_a_reg;
    logic [7:0]  mem_dout_reg;
    logic        if_finished_reg;
    logic [31:0] if_data_reg;
    logic        ls_finished_reg;
    logic [31:0] load_val_reg;

    logic        ls_req;
    logic        if_req;
    logic        io_stall;
    logic        write_go;
    logic [31:0] capture_word;
    logic [5:0]  shamt;
    logic [31:0] aligned_word;
    logic [2:0]  k_next;

    // A finish pulse means the requester still holds its enable this cycle;
    // that stale level must not start a second access.
    assign ls_req = ls_enable && !ls_finished_reg;
    assign if_req = if_enable && !if_finished_reg;

    // The write strobe is combinational so that a store byte lands in the
    // very cycle the I/O sink frees up. It is gated by rdy_in so a frozen
    // controller never repeats a write into the I/O sink.
    assign io_stall = (mem_a_reg >= IO_BASE) && io_buffer_full;
    assign write_go = (state_reg == ST_STORE) && rdy_in && !io_stall;

    // Bytes arrive in address order, so shifting each new byte in at the top
    // leaves byte 0 lowest once the access completes; the final shift drops
    // the unused low lanes for sub-word accesses.
    assign capture_word = {mem_din, assm_reg};
    assign shamt        = 6'd32 - {n_reg, 3'b000};
    assign aligned_word = capture_word >> shamt;
    assign k_next       = k_reg + 3'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg       <= ST_IDLE;
            k_reg           <= 3'd0;
            n_reg           <= 3'd1;
            base_reg        <= 32'h0;
            type_reg        <= 3'd0;
            sv_reg          <= 24'h0;
            assm_reg        <= 24'h0;
            suppress_reg    <= 1'b0;
            mem_a_reg       <= 32'h0;
            mem_dout_reg    <= 8'h0;
            if_finished_reg <= 1'b0;
            if_data_reg     <= 32'h0;
            ls_finished_reg <= 1'b0;
            load_val_reg    <= 32'h0;
        end else if (rdy_in) begin
            if_finished_reg <= 1'b0;
            ls_finished_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (!clear) begin
                        if (ls_req) begin
                            base_reg     <= addr;
                            type_reg     <= lsb_type[2:0];
                            n_reg        <= access_size(lsb_type[1:0]);
                            k_reg        <= 3'd0;
                            mem_a_reg    <= addr;
                            suppress_reg <= 1'b0;
                            if (lsb_type[3]) begin
                                state_reg    <= ST_STORE;
                                mem_dout_reg <= store_val[7:0];
                                sv_reg       <= store_val[31:8];
                            end else begin
                                state_reg <= ST_LOAD;
                            end
                        end else if (if_req) begin
                            base_reg  <= if_addr;
                            n_reg     <= 3'd4;
                            k_reg     <= 3'd0;
                            mem_a_reg <= if_addr;
                            state_reg <= ST_FETCH;
                        end
                    end
                end

                ST_LOAD, ST_FETCH: begin
                    if (clear) begin
                        state_reg <= ST_IDLE;
                        mem_a_reg <= 32'h0;
                    end else begin
                        // Index k > 0 sees the byte addressed in cycle k-1.
                        if (k_reg != 3'd0) begin
                            assm_reg <= capture_word[31:8];
                        end
                        if (k_reg == n_reg) begin
                            state_reg <= ST_IDLE;
                            mem_a_reg <= 32'h0;
                            if (state_reg == ST_LOAD) begin
                                ls_finished_reg <= 1'b1;
                                load_val_reg    <= extend_load(aligned_word, type_reg);
                            end else begin
                                if_finished_reg <= 1'b1;
                                if_data_reg     <= aligned_word;
                            end
                        end else begin
                            k_reg     <= k_next;
                            mem_a_reg <= (k_next < n_reg) ? base_reg + {29'h0, k_next}
                                                          : 32'h0;
                        end
                    end
                end

                ST_STORE: begin
                    // The ROB has committed this store: a flush only hides
                    // the completion pulse, the bytes still go out.
                    if (clear) begin
                        suppress_reg <= 1'b1;
                    end
                    if (write_go) begin
                        if (k_next == n_reg) begin
                            state_reg       <= ST_IDLE;
                            mem_a_reg       <= 32'h0;
                            mem_dout_reg    <= 8'h0;
                            ls_finished_reg <= !(suppress_reg || clear);
                            load_val_reg    <= 32'h0;
                        end else begin
                            k_reg        <= k_next;
                            mem_a_reg    <= base_reg + {29'h0, k_next};
                            mem_dout_reg <= sv_reg[7:0];
                            sv_reg       <= {8'h0, sv_reg[23:8]};
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    mem_a_reg <= 32'h0;
                end
            endcase
        end
    end

    assign mem_a       = mem_a_reg;
    assign mem_dout    = mem_dout_reg;
    assign mem_wr      = write_go;
    assign if_finished = if_finished_reg;
    assign if_data     = if_data_reg;
    assign ls_finished = ls_finished_reg;
    assign load_val    = load_val_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A behavioural byte RAM with
// one-cycle read latency answers the bus; expected finish values are queued
// when a request is driven and popped when the matching pulse appears.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic [7:0]  mem_din = 8'h0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_enable = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_finished;
    logic [31:0] if_data;
    logic        ls_enable = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_val = 32'h0;
    logic [3:0]  lsb_type = 4'h0;
    logic        ls_finished;
    logic [31:0] load_val;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_enable(if_enable), .if_addr(if_addr), .if_finished(if_finished),
        .if_data(if_data),
        .ls_enable(ls_enable), .addr(addr), .store_val(store_val),
        .lsb_type(lsb_type), .ls_finished(ls_finished), .load_val(load_val)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            passes++;
    endtask

    // Byte RAM: writes and reads sampled at the clock edge, read data one
    // cycle behind its address. Every write is logged for store checking.
    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wlog [$];

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wlog.push_back({mem_a, mem_dout});
        end
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    // Scoreboard
    logic [31:0] exp_ls [$];
    logic [31:0] exp_if [$];

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (ls_finished || if_finished)
                check("one_finish", {31'h0, ls_finished & if_finished}, 32'h0);
            if (ls_finished) begin
                if (exp_ls.size() == 0) check("unexpected_ls_finished", {31'h0, ls_finished}, 32'h0);
                else check("load_val", load_val, exp_ls.pop_front());
            end
            if (if_finished) begin
                if (exp_if.size() == 0) check("unexpected_if_finished", {31'h0, if_finished}, 32'h0);
                else check("if_data", if_data, exp_if.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ls_req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sv);
        ls_enable = 1'b1;
        lsb_type  = t;
        addr      = a;
        store_val = sv;
    endtask

    task automatic wait_ls(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ls_finished && lat < 40);
    endtask

    task automatic wait_if(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!if_finished && lat < 40);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] word);
        for (int k = 0; k < 4; k++) ram[a + k] = word[8*k +: 8];
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_a"}, mem_a, 32'h0);
        check({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
        check({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
        check({tag, "_ls_finished"}, {31'h0, ls_finished}, 32'h0);
        check({tag, "_if_finished"}, {31'h0, if_finished}, 32'h0);
        check({tag, "_load_val"}, load_val, 32'h0);
        check({tag, "_if_data"}, if_data, 32'h0);
    endtask

    typedef struct {
        logic [3:0]  typ;
        logic [31:0] a;
        logic [31:0] sv;
        logic        pre;
        logic [31:0] word;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat;
        int lat2;
        int n;
        int fin;

        vecs[0]  = '{LSB_LW,  32'h0000_0100, 32'h0,         1'b1, 32'h1234_5678, 32'h1234_5678, 6};
        vecs[1]  = '{LSB_LB,  32'h0000_0007, 32'h0,         1'b1, 32'h0000_0080, 32'hFFFF_FF80, 3};
        vecs[2]  = '{LSB_LBU, 32'h0000_0007, 32'h0,         1'b0, 32'h0,         32'h0000_0080, 3};
        vecs[3]  = '{LSB_LH,  32'h0000_0040, 32'h0,         1'b1, 32'h0000_8000, 32'hFFFF_8000, 4};
        vecs[4]  = '{LSB_LHU, 32'h0000_0040, 32'h0,         1'b0, 32'h0,         32'h0000_8000, 4};
        vecs[5]  = '{LSB_LH,  32'h0000_0050, 32'h0,         1'b1, 32'h9999_347F, 32'h0000_347F, 4};
        vecs[6]  = '{LSB_SH,  32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'h0,         3};
        vecs[7]  = '{LSB_SW,  32'h0000_0200, 32'hCAFE_F00D, 1'b0, 32'h0,         32'h0,         5};
        vecs[8]  = '{LSB_SB,  32'h0000_0010, 32'h1234_56A5, 1'b0, 32'h0,         32'h0,         2};
        vecs[9]  = '{LSB_LW,  32'hFFFF_FFFE, 32'h0,         1'b1, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 6};
        vecs[10] = '{LSB_LW,  32'h0000_0200, 32'h0,         1'b0, 32'h0,         32'hCAFE_F00D, 6};

        // Reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_in = 1'b0;
        tick();

        // Table-driven single accesses
        for (int i = 0; i < 11; i++) begin
            wlog.delete();
            if (vecs[i].pre) preload(vecs[i].a, vecs[i].word);
            exp_ls.push_back(vecs[i].exp);
            ls_req(vecs[i].typ, vecs[i].a, vecs[i].sv);
            wait_ls(lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            // Keep the enable up across the finish edge: it must not restart.
            tick();
            ls_enable = 1'b0;
            check($sformatf("v%0d_stale_req", i), mem_a, 32'h0);
            if (vecs[i].typ[3]) begin
                n = int'(access_size(vecs[i].typ[1:0]));
                check($sformatf("v%0d_write_count", i), wlog.size(), n);
                for (int k = 0; k < n && k < wlog.size(); k++)
                    check($sformatf("v%0d_write%0d", i, k), {24'h0, wlog[k][7:0]} | (wlog[k][39:8] - vecs[i].a) << 8,
                          {24'h0, vecs[i].sv[8*k +: 8]} | (k << 8));
            end else begin
                check($sformatf("v%0d_no_writes", i), wlog.size(), 0);
            end
            tick();
        end

        // Load and fetch together: load first, fetch right after
        preload(32'h300, 32'h1122_3344);
        preload(32'h400, 32'h5566_7788);
        exp_ls.push_back(32'h1122_3344);
        exp_if.push_back(32'h5566_7788);
        if_enable = 1'b1;
        if_addr   = 32'h400;
        ls_req(LSB_LW, 32'h300, 32'h0);
        wait_ls(lat);
        ls_enable = 1'b0;
        check("both_ls_latency", lat, 6);
        wait_if(lat2);
        if_enable = 1'b0;
        check("both_if_after_ls", lat2, 6);
        tick();

        // I/O store held off by a full buffer
        wlog.delete();
        exp_ls.push_back(32'h0);
        io_buffer_full = 1'b1;
        ls_req(LSB_SB, 32'h0003_0000, 32'h0000_005A);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("io_stall_c%0d_mem_wr", c), {31'h0, mem_wr}, 32'h0);
        end
        tick();
        io_buffer_full = 1'b0;
        #1;
        check("io_release_mem_wr", {31'h0, mem_wr}, 32'h1);
        check("io_release_mem_a", mem_a, 32'h0003_0000);
        check("io_release_mem_dout", {24'h0, mem_dout}, 32'h5A);
        tick();
        check("io_finish", {31'h0, ls_finished}, 32'h1);
        ls_enable = 1'b0;
        check("io_write_count", wlog.size(), 1);
        tick();

        // rdy_in low freezes an in-flight load
        exp_ls.push_back(32'h1234_5678);
        ls_req(LSB_LW, 32'h100, 32'h0);
        tick();
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("freeze_c%0d_mem_a", c), mem_a, 32'h100);
        end
        rdy_in = 1'b1;
        wait_ls(lat);
        ls_enable = 1'b0;
        check("freeze_resume_latency", lat, 5);
        tick();

        // Flush in the middle of a load: abort, no pulse
        ls_req(LSB_LW, 32'h100, 32'h0);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ls_enable = 1'b0;
        check("clr_load_mem_a", mem_a, 32'h0);
        check("clr_load_mem_wr", {31'h0, mem_wr}, 32'h0);
        fin = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            fin += int'(ls_finished);
        end
        check("clr_load_no_finish", fin, 0);

        // Flush in the middle of a store: all bytes written, no pulse
        wlog.delete();
        ls_req(LSB_SW, 32'h240, 32'h0102_0304);
        tick();
        tick();
        clear = 1'b1;
        ls_enable = 1'b0;
        tick();
        clear = 1'b0;
        fin = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            fin += int'(ls_finished);
        end
        check("clr_store_no_finish", fin, 0);
        check("clr_store_write_count", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            check($sformatf("clr_store_write%0d", k), wlog[k][39:8] ^ {wlog[k][7:0], 24'h0},
                  (32'h240 + k) ^ {8'(4 - k), 24'h0});

        // Reset in the middle of an access
        ls_req(LSB_LW, 32'h100, 32'h0);
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        ls_enable = 1'b0;
        check_outputs_zero("rst_mid");
        fin = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            fin += int'(ls_finished);
        end
        check("rst_mid_no_finish", fin, 0);

        // Recovery after reset
        exp_ls.push_back(32'h1234_5678);
        ls_req(LSB_LW, 32'h100, 32'h0);
        wait_ls(lat);
        ls_enable = 1'b0;
        check("post_rst_latency", lat, 6);
        tick();
        tick();

        check("scoreboard_drained", exp_ls.size() + exp_if.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
